// File: rtl/set_assoc_cache.sv
// N-way set-associative write-back/write-allocate cache, single-word lines, true LRU.
// Define CACHE_FLUSH_EN to add the flush/flush_done whole-cache write-back walk.
module set_assoc_cache #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SETS   = 16,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef CACHE_FLUSH_EN
    input  logic                  flush,
    output logic                  flush_done,
`endif
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           wb_count
);
    localparam int INDEX_WIDTH = $clog2(NUM_SETS);
    localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH;
    localparam int WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef logic [WAY_W-1:0]       way_t;
    typedef logic [INDEX_WIDTH-1:0] idx_t;
    typedef way_t [WAYS-1:0]        ages_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_WB,
`ifdef CACHE_FLUSH_EN
        S_FILL,
        S_FL_SCAN,
        S_FL_WB,
        S_FL_DONE
`else
        S_FILL
`endif
    } state_e;

    state_e                state_q, state_d;
    logic                  start_req;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    way_t                  victim_q;
    logic [WAYS-1:0]       valid_q [NUM_SETS];
    logic [WAYS-1:0]       dirty_q [NUM_SETS];
    logic [TAG_WIDTH-1:0]  tag_q   [NUM_SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][WAYS];
    ages_t                 ages_q  [NUM_SETS];
    logic                  resp_valid_q, resp_hit_q;
    logic [DATA_WIDTH-1:0] resp_rdata_q;
    logic [31:0]           hit_q, miss_q, wb_q;

    idx_t                  idx;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  hit, has_inv;
    way_t                  hit_way, victim;

    assign idx = addr_q[INDEX_WIDTH-1:0];
    assign tag = addr_q[ADDR_WIDTH-1:INDEX_WIDTH];

    // Accessed way becomes youngest; every way younger than it ages by one.
    function automatic ages_t lru_update(input ages_t a, input way_t acc);
        ages_t r;
        r = a;
        for (int w = 0; w < WAYS; w++) begin
            if (way_t'(w) == acc)    r[w] = '0;
            else if (a[w] < a[acc])  r[w] = a[w] + way_t'(1);
        end
        return r;
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        victim  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = way_t'(w);
            end
            if (!valid_q[idx][w]) begin
                has_inv = 1'b1;
                victim  = way_t'(w);
            end
        end
        if (!has_inv) begin
            for (int w = 0; w < WAYS; w++)
                if (ages_q[idx][w] == way_t'(WAYS - 1)) victim = way_t'(w);
        end
    end

`ifdef CACHE_FLUSH_EN
    idx_t fl_set_q;
    way_t fl_way_q;
    logic fl_dirty, fl_last;
    assign fl_dirty   = valid_q[fl_set_q][fl_way_q] && dirty_q[fl_set_q][fl_way_q];
    assign fl_last    = (fl_set_q == idx_t'(NUM_SETS - 1)) && (fl_way_q == way_t'(WAYS - 1));
    assign flush_done = (state_q == S_FL_DONE);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Memory outputs are decoded from state so reset drops mem_req asynchronously.
    always_comb begin
        state_d   = state_q;
        start_req = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_IDLE: begin
`ifdef CACHE_FLUSH_EN
                if (flush) begin
                    state_d = S_FL_SCAN;
                end else if (req_valid) begin
                    start_req = 1'b1;
                    state_d   = S_TAG;
                end
`else
                if (req_valid) begin
                    start_req = 1'b1;
                    state_d   = S_TAG;
                end
`endif
            end
            S_TAG: begin
                if (hit)                                                state_d = S_IDLE;
                else if (valid_q[idx][victim] && dirty_q[idx][victim])  state_d = S_WB;
                else                                                    state_d = S_FILL;
            end
            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[idx][victim_q], idx};
                mem_wdata = data_q[idx][victim_q];
                if (mem_ack) state_d = S_FILL;
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
                if (mem_ack) state_d = S_IDLE;
            end
`ifdef CACHE_FLUSH_EN
            S_FL_SCAN: begin
                if (fl_dirty)     state_d = S_FL_WB;
                else if (fl_last) state_d = S_FL_DONE;
            end
            S_FL_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[fl_set_q][fl_way_q], fl_set_q};
                mem_wdata = data_q[fl_set_q][fl_way_q];
                if (mem_ack) state_d = fl_last ? S_FL_DONE : S_FL_SCAN;
            end
            S_FL_DONE: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) ages_q[s][w] <= way_t'(w);
            end
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
            wb_q         <= '0;
`ifdef CACHE_FLUSH_EN
            fl_set_q     <= '0;
            fl_way_q     <= '0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_TAG: begin
                    if (hit) begin
                        if (we_q) dirty_q[idx][hit_way] <= 1'b1;
                        ages_q[idx]  <= lru_update(ages_q[idx], hit_way);
                        resp_valid_q <= 1'b1;
                        resp_hit_q   <= 1'b1;
                        resp_rdata_q <= we_q ? wdata_q : data_q[idx][hit_way];
                        hit_q        <= hit_q + 32'd1;
                    end else begin
                        victim_q <= victim;
                        miss_q   <= miss_q + 32'd1;
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        dirty_q[idx][victim_q] <= 1'b0;
                        wb_q                   <= wb_q + 32'd1;
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= we_q;
                        ages_q[idx]            <= lru_update(ages_q[idx], victim_q);
                        resp_valid_q           <= 1'b1;
                        resp_hit_q             <= 1'b0;
                        resp_rdata_q           <= we_q ? wdata_q : mem_rdata;
                    end
                end
`ifdef CACHE_FLUSH_EN
                S_FL_SCAN, S_FL_WB: begin
                    if ((state_q == S_FL_SCAN && !fl_dirty) || (state_q == S_FL_WB && mem_ack)) begin
                        valid_q[fl_set_q][fl_way_q] <= 1'b0;
                        dirty_q[fl_set_q][fl_way_q] <= 1'b0;
                        if (state_q == S_FL_WB) wb_q <= wb_q + 32'd1;
                        fl_way_q <= (fl_way_q == way_t'(WAYS - 1)) ? '0 : fl_way_q + way_t'(1);
                        if (fl_way_q == way_t'(WAYS - 1)) fl_set_q <= fl_set_q + idx_t'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Request latch and line storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (start_req) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
        if (state_q == S_TAG && hit && we_q) data_q[idx][hit_way] <= wdata_q;
        if (state_q == S_FILL && mem_ack) begin
            tag_q[idx][victim_q]  <= tag;
            data_q[idx][victim_q] <= we_q ? wdata_q : mem_rdata;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_rdata = resp_rdata_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign wb_count   = wb_q;
endmodule
